// File: rtl/looper_pkg.sv
// Shared AL-stage types for the looper core.
// Checkpoint entry layout and pointer helpers.
package looper_pkg;

  localparam int DEPTH = 2;
  localparam int IDX_W = 6;
  localparam int POS_W = 7;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [IDX_W-1:0] indx;
    logic [POS_W-1:0] pos;
  } ckpt_t;

  function automatic ptr_t ptr_dist(
    input ptr_t head,
    input ptr_t k
  );
    return k - head;
  endfunction

endpackage

// File: rtl/brnc_ckpt_fifo_if.sv
// AL-stage bundle between rename and the
// branch checkpoint queue.
interface brnc_ckpt_fifo_if
  import looper_pkg::*;
();

  logic             alloc_vld;
  logic [3:0]       brch;
  logic [IDX_W-1:0] base_indx;
  logic [4*POS_W-1:0] slot_pos;
  logic             cmt_brch;
  logic [IDX_W-1:0] cmt_brch_indx;
  logic             mis_pred;
  logic [IDX_W-1:0] brch_mis_indx;
  logic [1:0]       brnc_count;
  logic             stall;
  cnt_t             count;
  logic             rcvr_vld;
  logic [POS_W-1:0] rcvr_pos;
  logic             err;

  modport master (
    output alloc_vld, brch, base_indx,
    output slot_pos, cmt_brch,
    output cmt_brch_indx, mis_pred,
    output brch_mis_indx,
    input  brnc_count, stall, count,
    input  rcvr_vld, rcvr_pos, err
  );

  modport slave (
    input  alloc_vld, brch, base_indx,
    input  slot_pos, cmt_brch,
    input  cmt_brch_indx, mis_pred,
    input  brch_mis_indx,
    output brnc_count, stall, count,
    output rcvr_vld, rcvr_pos, err
  );

endinterface

// File: rtl/brnc_ckpt_match.sv
// Oldest-first search of occupied checkpoints
// for a mispredicted ROB index.
module brnc_ckpt_match
  import looper_pkg::*;
(
  input  ckpt_t            ent_i [DEPTH],
  input  ptr_t             head_i,
  input  cnt_t             count_i,
  input  logic [IDX_W-1:0] indx_i,
  output logic             hit_o,
  output ptr_t             k_o
);

  ptr_t slot;

  always_comb begin
    hit_o = 1'b0;
    k_o   = head_i;
    slot  = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_i + ptr_t'(i);
      if (!hit_o && (cnt_t'(i) < count_i) &&
          (ent_i[slot].indx == indx_i)) begin
        hit_o = 1'b1;
        k_o   = slot;
      end
    end
  end

endmodule

// File: rtl/brnc_ckpt_fifo.sv
// Branch checkpoint queue: saves free-list
// positions per branch, restores on mispredict.
module brnc_ckpt_fifo
  import looper_pkg::*;
(
  input logic             clk,
  input logic             rst,
  brnc_ckpt_fifo_if.slave bus
);

  localparam int SW = CNT_W + 3;

  ckpt_t            fifo_q [DEPTH];
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  cnt_t             cnt_q, cnt_d;
  cnt_t             base;
  logic             rv_q, rv_d;
  logic [POS_W-1:0] rp_q, rp_d;
  logic             err_q, err_d;

  logic [2:0]    pc;
  logic [2:0]    off [4];
  ptr_t          wptr [4];
  logic [SW-1:0] need;
  logic          stall;
  logic          hit;
  ptr_t          k;
  logic          alloc_en, same;
  logic          cmt_ok, cmt_do, cmt_err;

  always_comb begin
    pc = 3'd0;
    for (int i = 0; i < 4; i++) begin
      off[i]  = pc;
      wptr[i] = tail_q + ptr_t'(off[i]);
      pc      = pc + {2'b00, bus.brch[i]};
    end
  end

  // Slot 4-of-4 branches never fit, so the
  // truncated port value is harmless.
  assign need  = SW'(cnt_q) + SW'(pc);
  assign stall = bus.alloc_vld &&
                 (need > SW'(DEPTH));

  assign bus.brnc_count =
    bus.alloc_vld ? pc[1:0] : 2'd0;
  assign bus.stall    = stall;
  assign bus.count    = cnt_q;
  assign bus.rcvr_vld = rv_q;
  assign bus.rcvr_pos = rp_q;
  assign bus.err      = err_q;

  brnc_ckpt_match u_match (
    .ent_i   (fifo_q),
    .head_i  (head_q),
    .count_i (cnt_q),
    .indx_i  (bus.brch_mis_indx),
    .hit_o   (hit),
    .k_o     (k)
  );

  always_comb begin
    alloc_en = bus.alloc_vld & ~stall &
               ~bus.mis_pred;
    same     = bus.mis_pred & bus.cmt_brch &
               (bus.cmt_brch_indx ==
                bus.brch_mis_indx);
    cmt_ok   = (cnt_q != '0) &&
               (fifo_q[head_q].indx ==
                bus.cmt_brch_indx);
    cmt_do   = bus.cmt_brch & ~same & cmt_ok;
    cmt_err  = bus.cmt_brch & ~same & ~cmt_ok;
    head_d   = head_q + ptr_t'(cmt_do);
    tail_d   = tail_q;
    base     = cnt_q;
    rv_d     = 1'b0;
    rp_d     = rp_q;
    err_d    = err_q | cmt_err;
    if (bus.mis_pred && hit) begin
      tail_d = k + ptr_t'(1);
      base   = cnt_t'(ptr_dist(head_q, k)) +
               cnt_t'(1);
      rv_d   = 1'b1;
      rp_d   = fifo_q[k].pos;
    end else if (bus.mis_pred) begin
      err_d  = 1'b1;
    end else if (alloc_en) begin
      tail_d = tail_q + ptr_t'(pc);
    end
    cnt_d = base +
            (alloc_en ? cnt_t'(pc) : '0) -
            cnt_t'(cmt_do);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (alloc_en && bus.brch[i]) begin
        fifo_q[wptr[i]] <= '{
          indx: bus.base_indx + IDX_W'(i),
          pos:  bus.slot_pos[i*POS_W +: POS_W]
        };
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rv_q   <= 1'b0;
      rp_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rv_q   <= rv_d;
      rp_q   <= rp_d;
      err_q  <= err_d;
    end
  end

endmodule
